// File: rtl/output_conditioner_pkg.sv
// ============================================================================
// Module   : output_conditioner_pkg
// Brief    : Shared conditioner definitions: FSM state encodings and the
//            default dwell parameters, common to input/output conditioning.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package output_conditioner_pkg;

  // Default minimum dwell (level held for DEFAULT_WAITTIME+1 cycles)
  localparam int DEFAULT_WAITTIME     = 3;
  // Default dwell counter width; must hold DEFAULT_WAITTIME
  localparam int DEFAULT_COUNTERWIDTH = 3;

  // Conditioner states
  typedef enum logic [1:0] {
    STABLE  = 2'd0,  // dwell complete, nothing pending
    DWELL   = 2'd1,  // dwell running, nothing pending
    PENDING = 2'd2   // dwell running, one opposite-level change queued
  } cond_state_t;

endpackage : output_conditioner_pkg

`default_nettype wire

// File: rtl/output_conditioner_dwell_counter.sv
// ============================================================================
// Module   : dwell_counter
// Brief    : Dwell timer with synchronous clear and a saturating increment;
//            done is high while the count sits at waittime.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dwell_counter
  import output_conditioner_pkg::*;
#(
  parameter int counterwidth = DEFAULT_COUNTERWIDTH,
  parameter int waittime     = DEFAULT_WAITTIME
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam logic [counterwidth-1:0] c_limit = counterwidth'(waittime);
  localparam logic [counterwidth-1:0] c_one   = counterwidth'(1);

  logic [counterwidth-1:0] r_count;

  // Count up while enabled, stop at the limit so the counter never wraps
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (enable && (r_count != c_limit)) begin
      r_count <= r_count + c_one;
    end
  end

  assign done = (r_count == c_limit);

endmodule : dwell_counter

`default_nettype wire

// File: rtl/output_conditioner.sv
// ============================================================================
// Module   : output_conditioner
// Brief    : Glitch-free output level driver. Accepts rise/fall requests,
//            enforces a minimum dwell after every change, queues at most one
//            opposite-level change and emits registered edge pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module output_conditioner
  import output_conditioner_pkg::*;
#(
  parameter int counterwidth = DEFAULT_COUNTERWIDTH,
  parameter int waittime     = DEFAULT_WAITTIME
) (
  input  logic clk,
  input  logic reset,
  input  logic riserequest,
  input  logic fallrequest,
  output logic drive,
  output logic positiveedge,
  output logic negativeedge,
  output logic busy
);

  cond_state_t r_state;
  cond_state_t w_next_state;
  logic        w_toggle;
  logic        w_effective;
  logic        w_cancel;
  logic        w_done;
  logic        w_count_en;

  // A request only matters if it targets the opposite level; when both are
  // raised together the opposite-level one wins, so it is never a cancel.
  assign w_effective = drive ? fallrequest : riserequest;
  assign w_cancel    = (drive ? riserequest : fallrequest) && !w_effective;
  assign w_count_en  = (r_state != STABLE);

  dwell_counter #(
    .counterwidth (counterwidth),
    .waittime     (waittime)
  ) u_dwell_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_toggle),
    .enable (w_count_en),
    .done   (w_done)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= STABLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and toggle decision
  always_comb begin
    w_next_state = r_state;
    w_toggle     = 1'b0;
    case (r_state)
      STABLE: begin
        if (w_effective) begin
          w_toggle     = 1'b1;
          w_next_state = DWELL;
        end
      end
      DWELL: begin
        if (w_effective) begin
          // A request landing on the final dwell cycle is served at once
          if (w_done) begin
            w_toggle     = 1'b1;
            w_next_state = DWELL;
          end else begin
            w_next_state = PENDING;
          end
        end else if (w_done) begin
          w_next_state = STABLE;
        end
      end
      PENDING: begin
        if (w_cancel) begin
          // Cancelled change behaves as if never queued
          w_next_state = w_done ? STABLE : DWELL;
        end else if (w_done) begin
          w_toggle     = 1'b1;
          w_next_state = DWELL;
        end
      end
      default: begin
        w_next_state = STABLE;
      end
    endcase
  end

  // Output level, edge pulses and busy flag, all registered
  always_ff @(posedge clk) begin
    if (reset) begin
      drive        <= 1'b0;
      positiveedge <= 1'b0;
      negativeedge <= 1'b0;
      busy         <= 1'b0;
    end else begin
      drive        <= drive ^ w_toggle;
      positiveedge <= w_toggle && !drive;
      negativeedge <= w_toggle && drive;
      busy         <= (w_next_state != STABLE);
    end
  end

endmodule : output_conditioner

`default_nettype wire

// File: doc/output_conditioner.md
OUTPUT_CONDITIONER -- requirements
Module: output_conditioner

Interface
REQ-001 Parameter counterwidth, default 3: dwell counter width in bits; SHALL be >= log2(waittime+1).
REQ-002 Parameter waittime, default 3: minimum dwell; the output level SHALL be held for at least waittime+1 clk cycles after each change.
REQ-003 clk  input  1  sole clock; all state SHALL update on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 riserequest  input  1  one-cycle request to drive the output high.
REQ-006 fallrequest  input  1  one-cycle request to drive the output low.
REQ-007 drive  output  1  registered, glitch-free output level.
REQ-008 positiveedge  output  1  registered one-cycle pulse, high in the first cycle drive reads 1 after a change.
REQ-009 negativeedge  output  1  registered one-cycle pulse, high in the first cycle drive reads 0 after a change.
REQ-010 busy  output  1  registered; high while the dwell window is running or a change is pending.

Function
REQ-011 The FSM SHALL have three states: STABLE (dwell complete, nothing pending), DWELL (counting, nothing pending) and PENDING (counting, one opposite-level change queued); drive is a separate register.
REQ-012 A request SHALL be effective only when it targets the level opposite to the current drive; riserequest with drive=1 and fallrequest with drive=0 SHALL be ignored.
REQ-013 STABLE + effective request in cycle N: drive SHALL toggle at the end of cycle N (visible N+1), the matching edge pulse SHALL be high in cycle N+1 only, the counter SHALL clear to 0, and the state SHALL go to DWELL.
REQ-014 DWELL/PENDING: the counter SHALL increment each cycle while below waittime.
REQ-015 When the counter equals waittime: PENDING SHALL toggle drive at that edge, pulse, clear the counter and go to DWELL; DWELL SHALL go to STABLE.
REQ-016 DWELL + effective request: the state SHALL go to PENDING; if the counter equals waittime in that cycle, the toggle SHALL happen at that same edge as in REQ-015.
REQ-017 PENDING + a request for the current drive level SHALL cancel the pending change (back to DWELL) with no toggle and no pulse; another request for the pending level SHALL be a no-op.
REQ-018 If riserequest and fallrequest are asserted together, only the request opposite to the current drive SHALL be acted on, per REQ-012.
REQ-019 At most one change SHALL be queued; the counter SHALL never wrap, saturating at waittime.
REQ-020 busy SHALL be 1 exactly when the state is DWELL or PENDING; positiveedge and negativeedge SHALL never be high in the same cycle.

Reset
REQ-021 reset=1 at a posedge SHALL set drive=0, positiveedge=0, negativeedge=0, busy=0, counter=0 and state=STABLE, overriding all requests in that cycle.
REQ-022 Reset mid-dwell or while PENDING SHALL discard the queued change and SHALL NOT produce any edge pulse.
REQ-023 All outputs SHALL be 0 in the first cycle after reset deasserts, and a request in that cycle SHALL be accepted.

Structure
REQ-024 The state encodings (STABLE, DWELL, PENDING) SHALL live in the shared conditioner definitions include/package, together with the default waittime and counterwidth constants, so they are shared with the input conditioning logic.
REQ-025 The dwell counter (clear, saturating increment, done=count==waittime) SHALL be one sub-module, dwell_counter; the FSM and the output registers stay in output_conditioner.

Verification (waittime=3; cycle 0 = first cycle after reset deasserts)
REQ-026 riserequest in cycle 2 -> drive=1 from cycle 3; positiveedge=1 in cycle 3 only; busy=1 in cycles 3-6 and 0 from cycle 7.
REQ-027 rise in cycle 2, fall in cycle 4 -> drive high in cycles 3-6 exactly, low from cycle 7; negativeedge=1 in cycle 7 only; busy=1 through cycle 10.
REQ-028 rise in cycle 2, fall in cycle 4, rise in cycle 5 -> pending change cancelled; drive stays 1; no negativeedge; busy=0 from cycle 7.
REQ-029 rise and fall together in cycle 2 with drive=0 -> drive=1 from cycle 3; positiveedge pulse only. riserequest with drive=1 in STABLE -> no change, busy stays 0.
REQ-030 rise in cycle 2, fall in cycle 4, reset in cycle 5 -> drive=0, busy=0 from cycle 6; no negativeedge in any cycle.
